// File: rtl/vram_line_prefetcher_if.sv
// Line-request, pixel readout and VRAM read port of the VGA line prefetcher.
// The slave side is the prefetcher; the master side is the video timing / VRAM side.
interface vram_line_prefetcher_if #(
  parameter int ADDR_W = 18
);
  logic              line_req;
  logic [9:0]        line_idx;
  logic              line_swap;
  logic              pix_en;
  logic [7:0]        pix_data;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic              busy;
  logic              fetch_done;
  logic              err_overlap;
  logic              err_underrun;

  modport master (
    output line_req, line_idx, line_swap, pix_en, vram_data,
    input  pix_data, vram_addr, busy, fetch_done, err_overlap, err_underrun
  );

  modport slave (
    input  line_req, line_idx, line_swap, pix_en, vram_data,
    output pix_data, vram_addr, busy, fetch_done, err_overlap, err_underrun
  );
endinterface

// File: rtl/vram_line_prefetcher.sv
// Ping-pong line buffer: fetches one image row from VRAM into the back bank
// while the front bank is streamed out one byte per pixel enable.
module vram_line_prefetcher #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 480,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 18
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vram_line_prefetcher_if.slave   bus
);
  localparam int LW = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [LW-1:0]     col_q, col_d;
  logic              zero_fill_q, zero_fill_d;
  logic [2:0]        drain_q, drain_d;
  logic              pres_v_q, pres_v_d;
  logic [LW-1:0]     pres_col_q, pres_col_d;
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [LW-1:0]     pipe_col_q [RD_LAT];
  logic [LW-1:0]     pipe_col_d [RD_LAT];
  logic              busy_q, busy_d;
  logic              fetch_done_q, fetch_done_d;
  logic              err_overlap_q, err_overlap_d;
  logic              err_underrun_q, err_underrun_d;
  logic              bank_sel_q, bank_sel_d;
  logic              back_complete_q, back_complete_d;
  logic              front_valid_q, front_valid_d;
  logic [LW:0]       rd_col_q, rd_col_d;
  logic [7:0]        pix_data_q, pix_data_d;

  logic              eff_bank;
  logic              eff_valid;
  logic [LW:0]       eff_col;

  // Both banks in one array, indexed {bank, column}; not cleared by reset.
  logic [7:0]        mem [2*IMG_W];

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    vram_addr_d     = vram_addr_q;
    col_d           = col_q;
    zero_fill_d     = zero_fill_q;
    drain_d         = drain_q;
    pres_v_d        = 1'b0;
    pres_col_d      = pres_col_q;
    busy_d          = busy_q;
    fetch_done_d    = 1'b0;
    back_complete_d = back_complete_q;
    err_overlap_d   = err_overlap_q | (bus.line_req & busy_q);
    err_underrun_d  = err_underrun_q | (bus.line_swap & busy_q);

    case (state_q)
      IDLE: begin
        if (bus.line_req) begin
          zero_fill_d = (int'(bus.line_idx) >= IMG_H);
          base_d      = ADDR_W'(bus.line_idx) << LW;
          vram_addr_d = zero_fill_d ? '0 : base_d;
          col_d       = LW'(1);
          pres_v_d    = 1'b1;
          pres_col_d  = '0;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        vram_addr_d = zero_fill_q ? '0 : base_q + ADDR_W'(col_q);
        pres_v_d    = 1'b1;
        pres_col_d  = col_q;
        col_d       = col_q + LW'(1);
        if (col_q == LW'(IMG_W - 1)) begin
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last column's data lands RD_LAT cycles after it was presented.
        if (drain_q == 3'(RD_LAT)) begin
          fetch_done_d    = 1'b1;
          back_complete_d = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_v_d[0]   = pres_v_q;
    pipe_col_d[0] = pres_col_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_col_d[i] = pipe_col_q[i-1];
    end

    // A swap takes effect in the same cycle, so a coincident pix_en reads the new front.
    eff_bank  = bank_sel_q ^ bus.line_swap;
    eff_col   = bus.line_swap ? '0 : rd_col_q;
    eff_valid = bus.line_swap ? (back_complete_q & ~busy_q) : front_valid_q;
    if (bus.line_swap) back_complete_d = 1'b0;

    bank_sel_d    = eff_bank;
    front_valid_d = eff_valid;
    rd_col_d      = eff_col;
    pix_data_d    = pix_data_q;
    if (bus.pix_en) begin
      pix_data_d = (eff_valid && eff_col < (LW+1)'(IMG_W)) ? mem[{eff_bank, eff_col[LW-1:0]}] : 8'h00;
      if (eff_col < (LW+1)'(IMG_W)) rd_col_d = eff_col + (LW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      vram_addr_q     <= '0;
      col_q           <= '0;
      zero_fill_q     <= 1'b0;
      drain_q         <= '0;
      pres_v_q        <= 1'b0;
      pres_col_q      <= '0;
      pipe_v_q        <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_col_q[i] <= '0;
      busy_q          <= 1'b0;
      fetch_done_q    <= 1'b0;
      err_overlap_q   <= 1'b0;
      err_underrun_q  <= 1'b0;
      bank_sel_q      <= 1'b0;
      back_complete_q <= 1'b0;
      front_valid_q   <= 1'b0;
      rd_col_q        <= '0;
      pix_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      vram_addr_q     <= vram_addr_d;
      col_q           <= col_d;
      zero_fill_q     <= zero_fill_d;
      drain_q         <= drain_d;
      pres_v_q        <= pres_v_d;
      pres_col_q      <= pres_col_d;
      pipe_v_q        <= pipe_v_d;
      for (int i = 0; i < RD_LAT; i++) pipe_col_q[i] <= pipe_col_d[i];
      busy_q          <= busy_d;
      fetch_done_q    <= fetch_done_d;
      err_overlap_q   <= err_overlap_d;
      err_underrun_q  <= err_underrun_d;
      bank_sel_q      <= bank_sel_d;
      back_complete_q <= back_complete_d;
      front_valid_q   <= front_valid_d;
      rd_col_q        <= rd_col_d;
      pix_data_q      <= pix_data_d;
    end
  end

  // Writes always target the current back bank, even if a swap happened mid-fetch.
  always_ff @(posedge clk) begin
    if (pipe_v_q[RD_LAT-1])
      mem[{~bank_sel_q, pipe_col_q[RD_LAT-1]}] <= zero_fill_q ? 8'h00 : bus.vram_data;
  end

  assign bus.pix_data     = pix_data_q;
  assign bus.vram_addr    = vram_addr_q;
  assign bus.busy         = busy_q;
  assign bus.fetch_done   = fetch_done_q;
  assign bus.err_overlap  = err_overlap_q;
  assign bus.err_underrun = err_underrun_q;
endmodule

// File: tb/tb_vram_line_prefetcher.sv
// Randomized bench for vram_line_prefetcher: a VRAM model plus a line-level
// reference (expected front row, read pointer, pending back row).
module tb_vram_line_prefetcher;
  localparam int W      = 512;
  localparam int H      = 480;
  localparam int RD_LAT = 2;
  localparam int AW     = 18;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  vram_line_prefetcher_if #(.ADDR_W(AW)) bus();

  vram_line_prefetcher #(.IMG_W(W), .IMG_H(H), .RD_LAT(RD_LAT), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: data for the address presented two cycles earlier.
  logic [AW-1:0] hist0 = '0;
  logic [AW-1:0] hist1 = '0;
  always @(posedge clk) begin
    hist0 <= bus.vram_addr;
    hist1 <= hist0;
  end
  assign bus.vram_data = hist1[7:0] ^ hist1[15:8];

  // Line-level reference state.
  logic [7:0] front_line [W];
  logic [7:0] next_line  [W];
  bit         next_ok;
  int         rd_idx;
  logic [7:0] exp_pix;
  bit         exp_ovl;
  bit         exp_unr;

  function automatic logic [7:0] row_byte(input int row, input int c);
    int a;
    if (row >= H) return 8'h00;
    a = row * W + c;
    return 8'(a & 255) ^ 8'((a >> 8) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < W; c++) front_line[c] = 8'h00;
    next_ok = 0;
    rd_idx  = 0;
    exp_pix = 8'h00;
    exp_ovl = 0;
    exp_unr = 0;
  endtask

  task automatic model_swap(input bit fetching);
    for (int c = 0; c < W; c++) front_line[c] = (next_ok && !fetching) ? next_line[c] : 8'h00;
    next_ok = 0;
    rd_idx  = 0;
  endtask

  task automatic drive_pix(input bit pe);
    bus.pix_en = pe;
    if (pe) begin
      exp_pix = (rd_idx < W) ? front_line[rd_idx] : 8'h00;
      if (rd_idx < W) rd_idx++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.pix_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_pix_data got=%0h exp=0", bus.pix_data); end
    checks++; if (bus.vram_addr !== '0) begin errors++; $display("[TB] FAIL reset_vram_addr got=%0d exp=0", bus.vram_addr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_done got=%b exp=0", bus.fetch_done); end
    checks++; if (bus.err_overlap !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_overlap got=%b exp=0", bus.err_overlap); end
    checks++; if (bus.err_underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_underrun got=%b exp=0", bus.err_underrun); end
    model_reset();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_swap_no_fetch();
    bus.line_swap = 1'b1;
    model_swap(0);
    drive_pix(0);
    for (int n = 0; n < 5; n++) begin
      tick();
      bus.line_swap = 1'b0;
      checks++;
      if (bus.pix_data !== exp_pix) begin
        errors++; $display("[TB] FAIL swap_no_fetch_pix n=%0d got=%0h exp=%0h", n, bus.pix_data, exp_pix);
      end
      drive_pix(n < 4);
    end
    bus.pix_en = 1'b0;
  endtask

  // One fetch of 'row'; optional same-cycle swap, ignored line_req and mid-fetch swap.
  task automatic test_fetch(input int row, input bit same_swap, input int ovl_at, input int swap_at);
    int  exp_addr;
    bit  swapped;
    swapped       = 0;
    bus.line_req  = 1'b1;
    bus.line_idx  = 10'(row);
    bus.line_swap = same_swap;
    if (same_swap) model_swap(0);
    drive_pix(1'($urandom_range(0, 1)));
    for (int k = 1; k <= W + RD_LAT + 2; k++) begin
      tick();
      bus.line_req  = 1'b0;
      bus.line_swap = 1'b0;
      if (k <= W) begin
        exp_addr = (row < H) ? row * W + k - 1 : 0;
        checks++;
        if (bus.vram_addr !== AW'(exp_addr)) begin
          errors++; $display("[TB] FAIL fetch_addr row=%0d k=%0d got=%0d exp=%0d", row, k, bus.vram_addr, exp_addr);
        end
      end
      checks++;
      if (bus.busy !== (k <= W + RD_LAT)) begin
        errors++; $display("[TB] FAIL fetch_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= W + RD_LAT));
      end
      checks++;
      if (bus.fetch_done !== (k == W + RD_LAT + 1)) begin
        errors++; $display("[TB] FAIL fetch_done k=%0d got=%b exp=%b", k, bus.fetch_done, (k == W + RD_LAT + 1));
      end
      checks++;
      if (bus.pix_data !== exp_pix) begin
        errors++; $display("[TB] FAIL fetch_pix k=%0d got=%0h exp=%0h", k, bus.pix_data, exp_pix);
      end
      if (k == W + RD_LAT + 1) begin
        for (int c = 0; c < W; c++) next_line[c] = row_byte(row, c);
        next_ok = !swapped;
      end
      if (k == ovl_at) begin
        bus.line_req = 1'b1;
        bus.line_idx = 10'((row + 7) % H);
        exp_ovl      = 1;
      end
      if (k == swap_at) begin
        bus.line_swap = 1'b1;
        model_swap(1);
        exp_unr = 1;
        swapped = 1;
      end
      drive_pix(1'($urandom_range(0, 1)));
    end
    tick();
    bus.line_req  = 1'b0;
    bus.line_swap = 1'b0;
    checks++;
    if (bus.pix_data !== exp_pix) begin
      errors++; $display("[TB] FAIL fetch_pix_tail got=%0h exp=%0h", bus.pix_data, exp_pix);
    end
    bus.pix_en = 1'b0;
    checks++;
    if (bus.err_overlap !== exp_ovl) begin
      errors++; $display("[TB] FAIL err_overlap got=%b exp=%b", bus.err_overlap, exp_ovl);
    end
    checks++;
    if (bus.err_underrun !== exp_unr) begin
      errors++; $display("[TB] FAIL err_underrun got=%b exp=%b", bus.err_underrun, exp_unr);
    end
  endtask

  // Swap, then W+1 pixel enables with random gaps; a swap-cycle pix_en reads column 0.
  task automatic test_readout();
    int sent;
    bus.line_swap = 1'b1;
    model_swap(0);
    drive_pix(1);
    sent = 1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      bus.line_swap = 1'b0;
      bus.pix_en    = 1'b0;
      checks++;
      if (bus.pix_data !== exp_pix) begin
        errors++; $display("[TB] FAIL readout_pix n=%0d sent=%0d got=%0h exp=%0h", n, sent, bus.pix_data, exp_pix);
      end
      if (sent >= W + 1) break;
      if ($urandom_range(0, 3) != 0) begin
        drive_pix(1);
        sent++;
      end
    end
    bus.pix_en = 1'b0;
    checks++;
    if (sent != W + 1) begin
      errors++; $display("[TB] FAIL readout_budget sent=%0d exp=%0d", sent, W + 1);
    end
  endtask

  task automatic test_reset_mid_fetch(input int row);
    bus.line_req = 1'b1;
    bus.line_idx = 10'(row);
    drive_pix(0);
    for (int k = 1; k <= 300; k++) begin
      tick();
      bus.line_req = 1'b0;
      checks++;
      if (bus.vram_addr !== AW'(row * W + k - 1)) begin
        errors++; $display("[TB] FAIL rst_fetch_addr k=%0d got=%0d exp=%0d", k, bus.vram_addr, row * W + k - 1);
      end
    end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.pix_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_pix_data got=%0h exp=0", bus.pix_data); end
    checks++; if (bus.vram_addr !== '0) begin errors++; $display("[TB] FAIL midrst_vram_addr got=%0d exp=0", bus.vram_addr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err_overlap !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err_overlap got=%b exp=0", bus.err_overlap); end
    checks++; if (bus.err_underrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err_underrun got=%b exp=0", bus.err_underrun); end
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      checks++;
      if (bus.fetch_done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("[TB] FAIL midrst_no_done k=%0d done=%b busy=%b exp=0/0", k, bus.fetch_done, bus.busy);
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.line_req  = 1'b0;
    bus.line_idx  = '0;
    bus.line_swap = 1'b0;
    bus.pix_en    = 1'b0;
    model_reset();

    test_reset();
    test_swap_no_fetch();
    test_fetch(3, 0, 0, 0);
    test_readout();
    test_fetch(int'($urandom_range(0, H - 1)), 0, 0, 0);
    test_readout();
    test_fetch(480, 0, 0, 0);
    test_readout();
    test_fetch(int'($urandom_range(H, 1023)), 0, 0, 0);
    test_readout();
    test_fetch(int'($urandom_range(0, H - 1)), 0, 0, 0);
    test_fetch(int'($urandom_range(0, H - 1)), 1, 0, 0);
    test_readout();
    test_fetch(int'($urandom_range(0, H - 1)), 0, 100, 200);
    test_reset_mid_fetch(int'($urandom_range(0, H - 1)));
    test_fetch(int'($urandom_range(0, H - 1)), 0, 0, 0);
    test_readout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
